// File: rtl/sayac_izleyici.sv
// ============================================================================
// Module   : sayac_izleyici
// Purpose  : Watches an upstream alternating up/down counter during a busy
//            run and checks every step against the value predicted from the
//            previous sample, the captured step amount and the direction.
//            It reports the step count, a sticky error flag, the index of the
//            first bad step, the last sample, the number of ready cycles seen
//            while busy, and a one-cycle end-of-run pulse.
// Ports    : saat          - clock, rising edge
//            reset         - synchronous active-high reset
//            giris_sonuc   - counter value sample (8)
//            giris_mesgul  - counter busy flag
//            giris_hazir   - counter ready/limit flag
//            giris_miktar  - counter step amount (3)
//            giris_yon     - counter direction, 1 = up
//            adim_sayisi   - checked steps in current/last run, saturating (8)
//            hata          - sticky error flag for current/last run
//            hata_adim     - step index of first mismatch, 0 if none (8)
//            son_deger     - last sample taken while busy (8)
//            hazir_sayisi  - busy cycles with ready set, saturating (4)
//            tamam         - one-cycle end-of-run pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sayac_izleyici (
  input  logic       saat,
  input  logic       reset,
  input  logic [7:0] giris_sonuc,
  input  logic       giris_mesgul,
  input  logic       giris_hazir,
  input  logic [2:0] giris_miktar,
  input  logic       giris_yon,
  output logic [7:0] adim_sayisi,
  output logic       hata,
  output logic [7:0] hata_adim,
  output logic [7:0] son_deger,
  output logic [3:0] hazir_sayisi,
  output logic       tamam
);

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    IZLE  = 2'd1,
    BITTI = 2'd2
  } durum_t;

  // Phase of the alternating counter: the big step (amount) and the small
  // corrective step (one unit the other way) alternate.
  localparam logic BUYUK = 1'b0;
  localparam logic KUCUK = 1'b1;

  durum_t     durum;
  logic       faz;
  logic [7:0] taban;
  logic [2:0] miktar_k;
  logic       yon_k;

  logic [7:0] miktar_gen;
  logic [7:0] beklenen;
  logic [7:0] adim_art;
  logic [3:0] hazir_art;
  logic       uyumsuz;

  assign miktar_gen = {5'd0, miktar_k};

  // Predicted sample for this cycle; 8-bit arithmetic wraps naturally, so a
  // counter passing through 255/0 is not flagged.
  always_comb begin
    beklenen = taban;
    if (faz == BUYUK) begin
      beklenen = yon_k ? (taban + miktar_gen) : (taban - miktar_gen);
    end else begin
      beklenen = yon_k ? (taban - 8'd1) : (taban + 8'd1);
    end
  end

  assign adim_art  = (adim_sayisi == 8'hFF) ? adim_sayisi : (adim_sayisi + 8'd1);
  assign hazir_art = (hazir_sayisi == 4'hF) ? hazir_sayisi : (hazir_sayisi + 4'd1);

  // A changed step amount or direction mid-run is as much an error as a
  // wrong value.
  assign uyumsuz = (giris_sonuc != beklenen) ||
                   (giris_miktar != miktar_k) ||
                   (giris_yon != yon_k);

  always_ff @(posedge saat) begin
    if (reset) begin
      durum        <= BOS;
      faz          <= BUYUK;
      taban        <= 8'd0;
      miktar_k     <= 3'd0;
      yon_k        <= 1'b0;
      adim_sayisi  <= 8'd0;
      hata         <= 1'b0;
      hata_adim    <= 8'd0;
      son_deger    <= 8'd0;
      hazir_sayisi <= 4'd0;
      tamam        <= 1'b0;
    end else begin
      case (durum)
        BOS, BITTI: begin
          tamam <= 1'b0;
          if (giris_mesgul) begin
            // Run start: the first busy sample is the reference, not a step.
            durum        <= IZLE;
            faz          <= BUYUK;
            taban        <= giris_sonuc;
            son_deger    <= giris_sonuc;
            miktar_k     <= giris_miktar;
            yon_k        <= giris_yon;
            adim_sayisi  <= 8'd0;
            hata         <= 1'b0;
            hata_adim    <= 8'd0;
            hazir_sayisi <= {3'd0, giris_hazir};
          end else begin
            durum <= BOS;
          end
        end

        IZLE: begin
          if (giris_mesgul) begin
            adim_sayisi <= adim_art;
            // Always resync to the real sample so one bad step does not
            // cascade into a mismatch on every later step.
            taban       <= giris_sonuc;
            son_deger   <= giris_sonuc;
            if (giris_hazir) begin
              hazir_sayisi <= hazir_art;
            end
            if (miktar_k > 3'd1) begin
              faz <= ~faz;
            end else begin
              faz <= BUYUK;
            end
            if (uyumsuz) begin
              hata <= 1'b1;
              if (!hata) begin
                hata_adim <= adim_art;
              end
            end
          end else begin
            durum <= BITTI;
            tamam <= 1'b1;
          end
        end

        default: begin
          durum <= BOS;
          tamam <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sayac_izleyici.sv
// ============================================================================
// Module   : tb_sayac_izleyici
// Purpose  : Self-checking bench for sayac_izleyici. Each run pushes its
//            expected result record to a queue; the monitor pops and compares
//            it when the end-of-run pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sayac_izleyici;

  logic       saat = 1'b0;
  logic       reset;
  logic [7:0] giris_sonuc;
  logic       giris_mesgul;
  logic       giris_hazir;
  logic [2:0] giris_miktar;
  logic       giris_yon;
  logic [7:0] adim_sayisi;
  logic       hata;
  logic [7:0] hata_adim;
  logic [7:0] son_deger;
  logic [3:0] hazir_sayisi;
  logic       tamam;

  typedef struct {
    logic [7:0] adim;
    logic       hata;
    logic [7:0] hadim;
    logic [7:0] son;
    logic [3:0] hz;
  } sonuc_t;

  sonuc_t kuyruk[$];
  sonuc_t son_beklenen;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;
  logic onceki_tamam = 1'b0;

  sayac_izleyici dut (
    .saat         (saat),
    .reset        (reset),
    .giris_sonuc  (giris_sonuc),
    .giris_mesgul (giris_mesgul),
    .giris_hazir  (giris_hazir),
    .giris_miktar (giris_miktar),
    .giris_yon    (giris_yon),
    .adim_sayisi  (adim_sayisi),
    .hata         (hata),
    .hata_adim    (hata_adim),
    .son_deger    (son_deger),
    .hazir_sayisi (hazir_sayisi),
    .tamam        (tamam)
  );

  always #5 saat = ~saat;

  task automatic kontrol(input string etiket, input logic [31:0] gercek,
                         input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", etiket, gercek, beklenen, $time);
    end
  endtask

  task automatic beat(input logic m, input logic [7:0] s, input logic [2:0] k,
                      input logic y, input logic h);
    giris_mesgul = m;
    giris_sonuc  = s;
    giris_miktar = k;
    giris_yon    = y;
    giris_hazir  = h;
    @(posedge saat);
    #1;
  endtask

  task automatic bekle(input sonuc_t e);
    kuyruk.push_back(e);
  endtask

  task automatic tum_sifir(input string etiket);
    kontrol({etiket, "_adim"},  adim_sayisi, 0);
    kontrol({etiket, "_hata"},  hata, 0);
    kontrol({etiket, "_hadim"}, hata_adim, 0);
    kontrol({etiket, "_son"},   son_deger, 0);
    kontrol({etiket, "_hz"},    hazir_sayisi, 0);
    kontrol({etiket, "_tamam"}, tamam, 0);
  endtask

  // Monitor: compare the result outputs whenever the end-of-run pulse shows.
  always @(negedge saat) begin
    if (onceki_tamam) kontrol("tamam_tek_cevrim", tamam, 0);
    if (tamam && !onceki_tamam) begin
      if (kuyruk.size() == 0) begin
        kontrol("beklenmeyen_tamam", 1, 0);
      end else begin
        son_beklenen = kuyruk.pop_front();
        kontrol("adim_sayisi",  adim_sayisi,  son_beklenen.adim);
        kontrol("hata",         hata,         son_beklenen.hata);
        kontrol("hata_adim",    hata_adim,    son_beklenen.hadim);
        kontrol("son_deger",    son_deger,    son_beklenen.son);
        kontrol("hazir_sayisi", hazir_sayisi, son_beklenen.hz);
      end
    end
    onceki_tamam = tamam;
  end

  // Run A: up, amount 3, samples 10,13,12,15,14; ready on two busy cycles.
  task automatic kosu_a();
    bekle('{8'd4, 1'b0, 8'd0, 8'd14, 4'd2});
    beat(1, 8'd10, 3, 1, 1);
    beat(1, 8'd13, 3, 1, 0);
    beat(1, 8'd12, 3, 1, 0);
    beat(1, 8'd15, 3, 1, 1);
    beat(1, 8'd14, 3, 1, 0);
    beat(0, 8'd0,  3, 1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset wins over a busy input.
    reset = 1'b1;
    beat(1, 8'd55, 3, 1, 1);
    beat(1, 8'd56, 3, 1, 1);
    tum_sifir("reset");
    reset = 1'b0;

    // Ready while idle is ignored.
    beat(0, 8'd0, 0, 0, 1);
    beat(0, 8'd0, 0, 0, 1);
    kontrol("bos_hazir", hazir_sayisi, 0);

    kosu_a();
    repeat (3) beat(0, 8'd99, 0, 0, 1);
    // Results hold while idle.
    kontrol("tut_adim", adim_sayisi, 4);
    kontrol("tut_son",  son_deger, 14);
    kontrol("tut_hz",   hazir_sayisi, 2);

    // Run B: down, amount 1 (phase stays big).
    bekle('{8'd2, 1'b0, 8'd0, 8'd3, 4'd0});
    beat(1, 8'd5, 1, 0, 0);
    beat(1, 8'd4, 1, 0, 0);
    beat(1, 8'd3, 1, 0, 0);
    beat(0, 8'd0, 0, 0, 0);
    beat(0, 8'd0, 0, 0, 0);

    // Run C: value mismatch on step 3.
    bekle('{8'd4, 1'b1, 8'd3, 8'd15, 4'd0});
    beat(1, 8'd10, 3, 1, 0);
    beat(1, 8'd13, 3, 1, 0);
    beat(1, 8'd12, 3, 1, 0);
    beat(1, 8'd16, 3, 1, 0);
    beat(1, 8'd15, 3, 1, 0);
    beat(0, 8'd0, 0, 0, 0);
    beat(0, 8'd0, 0, 0, 0);

    // Run D: single busy cycle, amount 0.
    bekle('{8'd0, 1'b0, 8'd0, 8'd7, 4'd1});
    beat(1, 8'd7, 0, 1, 1);
    beat(0, 8'd0, 0, 0, 0);
    beat(0, 8'd0, 0, 0, 0);

    // Runs E and F back-to-back: wrap-around, then direction flip on step 2.
    bekle('{8'd2, 1'b0, 8'd0, 8'd0, 4'd0});
    beat(1, 8'd254, 3, 1, 0);
    beat(1, 8'd1,   3, 1, 0);
    beat(1, 8'd0,   3, 1, 0);
    beat(0, 8'd0,   3, 1, 0);
    bekle('{8'd2, 1'b1, 8'd2, 8'd0, 4'd0});
    beat(1, 8'd254, 3, 1, 0);
    beat(1, 8'd1,   3, 1, 0);
    beat(1, 8'd0,   3, 0, 0);
    beat(0, 8'd0,   0, 0, 0);
    beat(0, 8'd0,   0, 0, 0);

    // Run G: amount changes on step 1.
    bekle('{8'd1, 1'b1, 8'd1, 8'd13, 4'd0});
    beat(1, 8'd10, 3, 1, 0);
    beat(1, 8'd13, 2, 1, 0);
    beat(0, 8'd0, 0, 0, 0);
    beat(0, 8'd0, 0, 0, 0);

    // Run H: down, amount 3, alternating phases.
    bekle('{8'd3, 1'b0, 8'd0, 8'd15, 4'd0});
    beat(1, 8'd20, 3, 0, 0);
    beat(1, 8'd17, 3, 0, 0);
    beat(1, 8'd18, 3, 0, 0);
    beat(1, 8'd15, 3, 0, 0);
    beat(0, 8'd0, 0, 0, 0);
    beat(0, 8'd0, 0, 0, 0);

    // Run S: long run saturates both counters.
    bekle('{8'd255, 1'b0, 8'd0, 8'd9, 4'd15});
    for (int i = 0; i < 300; i++) beat(1, 8'd9, 0, 1, 1);
    beat(0, 8'd0, 0, 0, 0);
    beat(0, 8'd0, 0, 0, 0);

    // Reset on step 2 of a run: outputs clear, no end pulse.
    beat(1, 8'd10, 3, 1, 1);
    beat(1, 8'd13, 3, 1, 0);
    reset = 1'b1;
    beat(1, 8'd12, 3, 1, 0);
    tum_sifir("orta_reset");
    reset = 1'b0;
    repeat (3) beat(0, 8'd0, 0, 0, 0);
    kontrol("orta_reset_sonra_tamam", tamam, 0);

    // Clean run after the abort.
    kosu_a();

    for (int i = 0; i < 20 && kuyruk.size() != 0; i++) beat(0, 8'd0, 0, 0, 0);
    kontrol("bekleyen_kuyruk", kuyruk.size(), 0);

    $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sayac_izleyici.md
SAYAC_IZLEYICI -- requirements
Module: sayac_izleyici

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 saat  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 giris_sonuc  in  8  counter value sample from the upstream alternating counter.
REQ-005 giris_mesgul  in  1  counter busy flag; high for the duration of a run.
REQ-006 giris_hazir  in  1  counter ready/limit flag.
REQ-007 giris_miktar  in  3  step amount used by the counter.
REQ-008 giris_yon  in  1  direction used by the counter: 1 = up, 0 = down.
REQ-009 adim_sayisi  out  8  count of checked steps in the current or last run; saturates at 255.
REQ-010 hata  out  1  sticky error flag for the current or last run.
REQ-011 hata_adim  out  8  step index of the first mismatch; 0 if no mismatch.
REQ-012 son_deger  out  8  last giris_sonuc sampled while busy.
REQ-013 hazir_sayisi  out  4  count of busy cycles with giris_hazir=1; saturates at 15.
REQ-014 tamam  out  1  one-cycle end-of-run pulse.

Function
REQ-015 The FSM SHALL have three states: BOS (idle), IZLE (monitoring) and BITTI (done).
REQ-016 Run start is giris_mesgul=1 sampled in BOS or BITTI; on this edge:
- capture giris_sonuc into son_deger and into the expected-base register;
- capture giris_miktar and giris_yon;
- phase <= BUYUK;
- adim_sayisi, hata, hata_adim <= 0;
- hazir_sayisi <= giris_hazir;
- next state IZLE.
REQ-017 Expected value in IZLE SHALL be computed from the base register, 8-bit modulo 256:
- phase BUYUK: base+miktar if yon=1, else base-miktar;
- phase KUCUK: base-1 if yon=1, else base+1.
REQ-018 Each IZLE cycle with giris_mesgul=1 is one step, and SHALL perform all of the following:
- adim_sayisi increments, saturating at 255;
- base <= giris_sonuc, son_deger <= giris_sonuc;
- hazir_sayisi increments if giris_hazir=1, saturating at 15.
REQ-019 Phase SHALL toggle after every step when captured miktar > 1, and SHALL stay BUYUK when captured miktar <= 1.
REQ-020 A step SHALL be a mismatch when any of the following holds:
- giris_sonuc differs from the expected value;
- giris_miktar differs from the captured miktar;
- giris_yon differs from the captured yon.
REQ-021 On a mismatch, hata <= 1 (sticky); hata_adim <= the incremented step index, only on the first mismatch of the run.
REQ-022 The base SHALL be resynchronised to the sampled value even after a mismatch, so later steps are checked against actual data.
REQ-023 giris_mesgul=0 in IZLE SHALL move the FSM to BITTI; tamam=1 only while in BITTI.
REQ-024 From BITTI the FSM SHALL go to BOS if giris_mesgul=0, or start a new run per REQ-016 if giris_mesgul=1 (back-to-back runs).
REQ-025 Result outputs SHALL hold their values in BOS and BITTI until the next run start.
REQ-026 A single-cycle busy pulse (e.g. miktar=0) SHALL complete with adim_sayisi=0 and hata=0.
REQ-027 Wrap-around SHALL NOT be an error: base 254, yon=1, miktar=3 SHALL expect 1.
REQ-028 giris_hazir outside busy cycles SHALL be ignored.
REQ-029 Latency: every output SHALL be registered and reflect the input sample one cycle later.

Reset
REQ-030 On reset all outputs and internal registers SHALL be 0, phase BUYUK, and state BOS, on the next edge.
REQ-031 Reset SHALL take priority over every other event, including mid-run; no tamam pulse SHALL be produced for an aborted run.

Verification
REQ-032 Up, miktar=3: busy samples 10,13,12,15,14 then mesgul=0 -> adim_sayisi=4, hata=0, son_deger=14, tamam high exactly one cycle.
REQ-033 Down, miktar=1: busy samples 5,4,3 -> adim_sayisi=2, hata=0, son_deger=3.
REQ-034 Up, miktar=3, samples 10,13,12,16,15 -> hata=1, hata_adim=3, adim_sayisi=4.
REQ-035 miktar=0, one busy cycle at 7 -> adim_sayisi=0, son_deger=7, hata=0, tamam pulse.
REQ-036 Up, miktar=3, samples 254,1,0 -> hata=0; the same run with giris_yon flipped on step 2 -> hata=1, hata_adim=2.
REQ-037 Reset asserted on step 2 of a run -> all outputs 0 next cycle, no tamam, and a new run starts cleanly afterwards.
